// File: rtl/tmr_pkg.sv
// Shared constants and types for the TMR encoder slice.
package tmr_pkg;

  localparam int DATA_LEN = 16;

  localparam logic [1:0] LANE_0    = 2'd0;
  localparam logic [1:0] LANE_1    = 2'd1;
  localparam logic [1:0] LANE_2    = 2'd2;
  localparam logic [1:0] LANE_NONE = 2'd3;

  typedef enum logic {
    INJ_DISARMED = 1'b0,
    INJ_ARMED    = 1'b1
  } inj_state_e;

endpackage

// File: rtl/tmr_skid_buf.sv
// Two-entry skid buffer: output register plus one skid register, registered in_ready.
module tmr_skid_buf #(
  parameter int width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [width-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [width-1:0] skid_data;
  logic             skid_valid;
  logic             skid_valid_n;
  logic             in_xfer;
  logic             out_free;

  assign in_xfer  = in_valid & in_ready;
  assign out_free = ~out_valid | out_ready;

  // The output register drains or is empty, so the skid entry never survives the edge.
  always_comb begin
    skid_valid_n = skid_valid;
    if (out_free) begin
      skid_valid_n = 1'b0;
    end else if (in_xfer) begin
      skid_valid_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data   <= '0;
      out_valid  <= 1'b0;
      skid_data  <= '0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b0;
    end else begin
      if (out_free) begin
        if (skid_valid) begin
          out_data  <= skid_data;
          out_valid <= 1'b1;
        end else if (in_xfer) begin
          out_data  <= in_data;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (in_xfer) begin
        skid_data <= in_data;
      end
      skid_valid <= skid_valid_n;
      in_ready   <= ~skid_valid_n;
    end
  end

endmodule

// File: rtl/tmr_encoder.sv
// Triplicates each buffered word into a 3-lane codeword, with one-shot fault injection and a transfer counter.
//   state        | meaning
//   INJ_DISARMED | no corruption pending; inj_arm captures lane/mask
//   INJ_ARMED    | captured mask applied to captured lane until the next output transfer
module tmr_encoder
  import tmr_pkg::*;
#(
  parameter int data_len = DATA_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [data_len-1:0]   in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [3*data_len-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic                  inj_arm,
  input  logic [1:0]            inj_lane,
  input  logic [data_len-1:0]   inj_mask,
  output logic                  inj_done,
  output logic [15:0]           word_cnt
);

  logic [data_len-1:0]   word;
  logic [3*data_len-1:0] flip;
  logic                  out_xfer;
  inj_state_e            state, state_n;
  logic [1:0]            cap_lane;
  logic [data_len-1:0]   cap_mask;

  tmr_skid_buf #(.width(data_len)) u_skid_buf (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (word),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  assign out_xfer = out_valid & out_ready;

  always_comb begin
    state_n = state;
    case (state)
      INJ_DISARMED: if (inj_arm)  state_n = INJ_ARMED;
      INJ_ARMED:    if (out_xfer) state_n = INJ_DISARMED;
      default:      state_n = INJ_DISARMED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= INJ_DISARMED;
      cap_lane <= LANE_NONE;
      cap_mask <= '0;
      inj_done <= 1'b0;
      word_cnt <= 16'd0;
    end else begin
      state <= state_n;
      if (state == INJ_DISARMED && inj_arm) begin
        cap_lane <= inj_lane;
        cap_mask <= inj_mask;
      end
      inj_done <= (state == INJ_ARMED) && out_xfer;
      if (out_xfer) begin
        word_cnt <= word_cnt + 16'd1;
      end
    end
  end

  // LANE_NONE falls through to the default so an armed no-lane request still completes.
  always_comb begin
    flip = '0;
    if (state == INJ_ARMED && out_valid) begin
      case (cap_lane)
        LANE_0:  flip[data_len-1:0]            = cap_mask;
        LANE_1:  flip[2*data_len-1:data_len]   = cap_mask;
        LANE_2:  flip[3*data_len-1:2*data_len] = cap_mask;
        default: flip = '0;
      endcase
    end
  end

  assign out_data = {3{word}} ^ flip;

endmodule

// File: tb/tb_tmr_encoder.sv
// Directed scoreboard bench for tmr_encoder: codewords, backpressure, injection, counter wrap, reset.
module tb_tmr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [47:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        inj_arm;
  logic [1:0]  inj_lane;
  logic [15:0] inj_mask;
  logic        inj_done;
  logic [15:0] word_cnt;

  typedef struct packed {
    logic [15:0] word;
    logic [1:0]  lane;
    logic [15:0] mask;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_err  = 0;
  int   n_done = 0;
  int   sent   = 0;

  tmr_encoder #(.data_len(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .inj_arm   (inj_arm),
    .inj_lane  (inj_lane),
    .inj_mask  (inj_mask),
    .inj_done  (inj_done),
    .word_cnt  (word_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] model(input exp_t e);
    logic [47:0] cw;
    cw = {e.word, e.word, e.word};
    case (e.lane)
      2'd0:    cw[15:0]  = cw[15:0]  ^ e.mask;
      2'd1:    cw[31:16] = cw[31:16] ^ e.mask;
      2'd2:    cw[47:32] = cw[47:32] ^ e.mask;
      default: cw = cw;
    endcase
    return cw;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transfers happen at the next posedge; inputs are stable at the negedge.
  always @(negedge clk) begin
    if (inj_done === 1'b1) n_done++;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 64'(out_valid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("codeword", 64'(out_data), 64'(model(mon_e)));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w, input logic [1:0] lane, input logic [15:0] mask);
    int k = 0;
    in_data  = w;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    if (in_ready !== 1'b1) begin
      check("send_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
    end else begin
      sb.push_back('{word: w, lane: lane, mask: mask});
      sent++;
      tick();
    end
  endtask

  task automatic drain();
    int k = 0;
    while ((sb.size() != 0 || out_valid === 1'b1) && k < 40) begin
      tick();
      k++;
    end
    check("drain_left", 64'(sb.size()), 64'd0);
    tick();
    tick();
  endtask

  task automatic arm(input logic [1:0] lane, input logic [15:0] mask);
    inj_arm  = 1'b1;
    inj_lane = lane;
    inj_mask = mask;
    tick();
    inj_arm  = 1'b0;
    inj_lane = 2'd3;
    inj_mask = 16'h0000;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_data = '0; in_valid = 1'b0; out_ready = 1'b1;
    inj_arm = 1'b0; inj_lane = 2'd3; inj_mask = '0;
    repeat (3) tick();
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_word_cnt",  64'(word_cnt),  64'd0);
    check("rst_inj_done",  64'(inj_done),  64'd0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Streaming with one-cycle latency and no bubbles
    send(16'h0001, 2'd3, 16'h0);
    check("lat_valid", 64'(out_valid), 64'd1);
    check("lat_data",  64'(out_data),  64'h0000_0001_0001_0001);
    send(16'h0002, 2'd3, 16'h0);
    check("stream_data2", 64'(out_data), 64'h0000_0002_0002_0002);
    send(16'h0003, 2'd3, 16'h0);
    send(16'h0004, 2'd3, 16'h0);
    check("stream_data4", 64'(out_data), 64'h0000_0004_0004_0004);
    in_valid = 1'b0;
    drain();
    check("stream_word_cnt", 64'(word_cnt), 64'd4);

    // Backpressure into the skid register
    out_ready = 1'b0;
    send(16'hAAAA, 2'd3, 16'h0);
    check("bp_ready_after_1", 64'(in_ready), 64'd1);
    send(16'h5555, 2'd3, 16'h0);
    in_valid = 1'b0;
    check("bp_ready_low", 64'(in_ready), 64'd0);
    check("bp_hold_data", 64'(out_data), 64'h0000_AAAA_AAAA_AAAA);
    tick();
    check("bp_still_low", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    tick();
    check("bp_ready_rise", 64'(in_ready), 64'd1);
    check("bp_skid_moved", 64'(out_data), 64'h0000_5555_5555_5555);
    drain();
    check("bp_word_cnt", 64'(word_cnt), 64'(sent));

    // Injection on lane 1
    n_done = 0;
    arm(2'd1, 16'h00FF);
    send(16'h1234, 2'd1, 16'h00FF);
    in_valid = 1'b0;
    check("inj1_data", 64'(out_data), 64'h0000_1234_12CB_1234);
    drain();
    check("inj1_done_cnt", 64'(n_done), 64'd1);
    send(16'h7777, 2'd3, 16'h0);
    in_valid = 1'b0;
    drain();
    check("inj1_clean_next", 64'(n_done), 64'd1);

    // Arm coinciding with a transfer: that word clean, the next corrupted
    n_done = 0;
    send(16'h1111, 2'd3, 16'h0);
    in_valid = 1'b0;
    arm(2'd2, 16'hFFFF);
    send(16'h2222, 2'd2, 16'hFFFF);
    in_valid = 1'b0;
    check("inj2_data", 64'(out_data), 64'h0000_DDDD_2222_2222);
    drain();
    check("inj2_done_cnt", 64'(n_done), 64'd1);

    // Lane 3 consumes the arm without altering bits
    n_done = 0;
    arm(2'd3, 16'hFFFF);
    send(16'h0F0F, 2'd3, 16'h0);
    in_valid = 1'b0;
    drain();
    check("inj3_done_cnt", 64'(n_done), 64'd1);

    // Reset with both entries full and armed
    out_ready = 1'b0;
    arm(2'd0, 16'hFFFF);
    send(16'hA1A1, 2'd0, 16'hFFFF);
    send(16'hB2B2, 2'd0, 16'hFFFF);
    in_valid = 1'b0;
    check("full_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b1;
    tick();
    tick();
    sb.delete();
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_data",  64'(out_data),  64'd0);
    check("mid_rst_in_ready",  64'(in_ready),  64'd0);
    check("mid_rst_word_cnt",  64'(word_cnt),  64'd0);
    rst = 1'b0;
    sent = 0;
    tick();
    check("rel_in_ready",  64'(in_ready),  64'd1);
    check("rel_out_valid", 64'(out_valid), 64'd0);
    check("rel_word_cnt",  64'(word_cnt),  64'd0);
    n_done = 0;
    out_ready = 1'b1;
    send(16'hBEEF, 2'd3, 16'h0);
    in_valid = 1'b0;
    check("rel_clean_data", 64'(out_data), 64'h0000_BEEF_BEEF_BEEF);
    drain();
    check("rel_no_done", 64'(n_done), 64'd0);
    check("rel_word_cnt1", 64'(word_cnt), 64'd1);

    // Counter wrap
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sent = 0;
    tick();
    for (int i = 0; i < 65534; i++) begin
      send(16'(i), 2'd3, 16'h0);
    end
    in_valid = 1'b0;
    drain();
    check("wrap_pre", 64'(word_cnt), 64'hFFFE);
    for (int i = 0; i < 3; i++) begin
      send(16'(16'hC000 + i), 2'd3, 16'h0);
    end
    in_valid = 1'b0;
    drain();
    check("wrap_post", 64'(word_cnt), 64'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tmr_encoder.md
TMR_ENCODER -- requirements
Module: tmr_encoder

Interface
REQ-001 Parameter data_len, default 16, meaning width of one lane and of the input word.
REQ-002 Port clk input 1: single clock; all state updates on posedge clk.
REQ-003 Port rst input 1: reset, synchronous, active-high.
REQ-004 Port in_data input data_len: word to be triplicated.
REQ-005 Port in_valid input 1: in_data valid.
REQ-006 Port in_ready output 1: block can accept a word this cycle.
REQ-007 Port out_data output 3*data_len: codeword; lane0 [15:0], lane1 [31:16], lane2 [47:32] (for data_len=16).
REQ-008 Port out_valid output 1: out_data valid.
REQ-009 Port out_ready input 1: consumer (the TMR decoder) accepts; may be tied high.
REQ-010 Port inj_arm input 1: one-cycle request to corrupt the next transferred codeword.
REQ-011 Port inj_lane input 2: target lane, 0..2; value 3 means no lane is corrupted.
REQ-012 Port inj_mask input data_len: XOR mask applied to the target lane.
REQ-013 Port inj_done output 1: one-cycle pulse after a corrupted codeword transfers.
REQ-014 Port word_cnt output 16: count of completed output transfers.

Function
REQ-015 Input transfer occurs when in_valid and in_ready are both high on a clock edge; output transfer occurs when out_valid and out_ready are both high.
REQ-016 Datapath is a 2-entry skid buffer (output register plus one skid register); in_ready is registered and equals "skid register empty".
REQ-017 Latency: a word accepted at edge N is presented on out_data with out_valid high from edge N+1 when the output register is empty or transferring at edge N.
REQ-018 Throughput: one word per cycle sustained while out_ready is high; no bubbles.
REQ-019 When out_ready is low with output register full, the next accepted word goes to the skid register and in_ready drops at the following edge.
REQ-020 When out_ready returns high, the skid word moves to the output register on that transfer edge and in_ready rises at the same edge.
REQ-021 Words leave in acceptance order; no word is dropped or duplicated.
REQ-022 Uncorrupted codeword = {w, w, w}, where w is the stored data_len-bit word.
REQ-023 Injection FSM states: DISARMED, ARMED.
REQ-024 DISARMED and inj_arm high: capture inj_lane and inj_mask, go to ARMED at the next edge.
REQ-025 ARMED: inj_arm is ignored; the captured mask is XORed onto the captured lane of out_data whenever out_valid is high.
REQ-026 ARMED and an output transfer: return to DISARMED and pulse inj_done high for the following cycle.
REQ-027 inj_arm coinciding with a transfer while DISARMED: that transfer is uncorrupted; the next transfer is corrupted.
REQ-028 Captured lane 3: no bits altered; the FSM still consumes the arm and still pulses inj_done.
REQ-029 word_cnt increments by 1 per output transfer, modulo 2^16 (0xFFFF wraps to 0x0000).

Reset
REQ-030 While rst is high at a clock edge, the block enters this state:
- out_valid = 0, out_data = 0, in_ready = 0
- skid and output registers empty, their contents discarded
- FSM = DISARMED, inj_done = 0, word_cnt = 0
REQ-031 in_ready is 1 in the first cycle after rst deasserts.
REQ-032 Reset asserted mid-stream discards all buffered words and any pending injection; no partial codeword is output afterwards.

Structure
REQ-033 Shared package tmr_pkg holds:
- DATA_LEN default constant (16)
- lane index constants and the no-corruption value 3
- injection FSM state enum
REQ-034 The skid buffer is a sub-module, tmr_skid_buf, parameterised by width.
REQ-035 Replication, injection and counting are implemented in tmr_encoder.

Verification
REQ-036 Stream 0x0001..0x0004 with out_ready=1 -> out_data 0x000100010001..0x000400040004 on consecutive cycles, 1-cycle latency; word_cnt=4.
REQ-037 Hold out_ready=0 and offer 0xAAAA then 0x5555 -> in_ready low after the second word is accepted; releasing out_ready -> 0xAAAA then 0x5555 codewords, no loss.
REQ-038 Pulse inj_arm with lane=1, mask=0x00FF, then send 0x1234 -> out_data 0x1234_12CB_1234; inj_done pulses once; the next word is clean.
REQ-039 Assert inj_arm during a transfer of 0x1111, then send 0x2222 with lane=2, mask=0xFFFF -> 0x1111 codeword clean; 0x2222 codeword = 0xDDDD_2222_2222.
REQ-040 Preload word_cnt to 0xFFFE by sending 65534 words, then send 3 more -> word_cnt reads 0x0001.
REQ-041 Assert rst with both buffer entries full and ARMED -> after release: out_valid=0, word_cnt=0, in_ready=1; no corruption on the next word.
